// File: rtl/scarv_cop_palu_mul_seq_pkg.sv
// ============================================================================
// Module : scarv_cop_palu_mul_seq_pkg
// Brief  : Pack-width codes, sequencer state encoding, pack-width legality.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scarv_cop_palu_mul_seq_pkg;

   localparam logic [2:0] c_PW_1  = 3'b001;
   localparam logic [2:0] c_PW_2  = 3'b010;
   localparam logic [2:0] c_PW_4  = 3'b011;
   localparam logic [2:0] c_PW_8  = 3'b100;
   localparam logic [2:0] c_PW_16 = 3'b101;

   typedef enum logic [1:0] {
      MSEQ_IDLE  = 2'b00,
      MSEQ_RUN   = 2'b01,
      MSEQ_DRAIN = 2'b10,
      MSEQ_RESP  = 2'b11
   } mseq_state_t;

   function automatic logic pw_legal(input logic [2:0] pw);
      return (pw == c_PW_1) || (pw == c_PW_2) || (pw == c_PW_4) ||
             (pw == c_PW_8) || (pw == c_PW_16);
   endfunction

endpackage

`default_nettype wire

// File: rtl/scarv_cop_palu_mul_seq.sv
// ============================================================================
// Module : scarv_cop_palu_mul_seq
// Brief  : Issue/response sequencer in front of the packed shift-add multiplier.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scarv_cop_palu_mul_seq
   import scarv_cop_palu_mul_seq_pkg::*;
(
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [2:0]  req_pw,
   input  logic        req_hi,
   input  logic [3:0]  req_rd,
   input  logic        flush,
   output logic        mul_start,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic [2:0]  mul_pw,
   input  logic        mul_done,
   input  logic [63:0] mul_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_rd,
   output logic        rsp_err
);

   mseq_state_t r_state;
   mseq_state_t w_state_nxt;

   logic [31:0] r_mul_a;
   logic [31:0] r_mul_b;
   logic [2:0]  r_mul_pw;
   logic        r_hi;
   logic [31:0] r_rsp_data;
   logic [3:0]  r_rsp_rd;
   logic        r_rsp_err;

   logic        w_accept;
   logic        w_legal;
   logic        w_capture;

   assign w_legal   = pw_legal(req_pw);
   assign w_accept  = (r_state == MSEQ_IDLE) && req_valid && !flush;
   assign w_capture = (r_state == MSEQ_RUN) && mul_done && !flush;

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state <= MSEQ_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // DRAIN keeps start high so the multiplier counter always wraps to 0.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MSEQ_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_legal ? MSEQ_RUN : MSEQ_RESP;
            end
         end
         MSEQ_RUN: begin
            if (mul_done) begin
               w_state_nxt = flush ? MSEQ_IDLE : MSEQ_RESP;
            end else if (flush) begin
               w_state_nxt = MSEQ_DRAIN;
            end
         end
         MSEQ_DRAIN: begin
            if (mul_done) begin
               w_state_nxt = MSEQ_IDLE;
            end
         end
         MSEQ_RESP: begin
            if (rsp_ready || flush) begin
               w_state_nxt = MSEQ_IDLE;
            end
         end
         default: w_state_nxt = MSEQ_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_mul_pw   <= '0;
         r_hi       <= 1'b0;
         r_rsp_data <= '0;
         r_rsp_rd   <= '0;
         r_rsp_err  <= 1'b0;
      end else if (w_accept) begin
         r_mul_a    <= req_a;
         r_mul_b    <= req_b;
         r_mul_pw   <= req_pw;
         r_hi       <= req_hi;
         r_rsp_rd   <= req_rd;
         r_rsp_data <= '0;
         r_rsp_err  <= !w_legal;
      end else if (w_capture) begin
         r_rsp_data <= r_hi ? mul_result[63:32] : mul_result[31:0];
         r_rsp_err  <= 1'b0;
      end
   end

   assign req_ready = (r_state == MSEQ_IDLE);
   assign mul_start = (r_state == MSEQ_RUN) || (r_state == MSEQ_DRAIN);
   assign rsp_valid = (r_state == MSEQ_RESP);
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign mul_pw    = r_mul_pw;
   assign rsp_data  = r_rsp_data;
   assign rsp_rd    = r_rsp_rd;
   assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_scarv_cop_palu_mul_seq.sv
// ============================================================================
// Module : tb_scarv_cop_palu_mul_seq
// Brief  : Directed vector bench with a behavioural packed multiplier model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scarv_cop_palu_mul_seq;
   import scarv_cop_palu_mul_seq_pkg::*;

   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [2:0]  req_pw = '0;
   logic        req_hi = 1'b0;
   logic [3:0]  req_rd = '0;
   logic        flush = 1'b0;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [2:0]  mul_pw;
   logic        mul_done;
   logic [63:0] mul_result;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_rd;
   logic        rsp_err;

   int n_chk = 0;
   int n_err = 0;

   always #5 g_clk = ~g_clk;

   scarv_cop_palu_mul_seq u_dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_pw(req_pw), .req_hi(req_hi), .req_rd(req_rd),
      .flush(flush),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_pw(mul_pw),
      .mul_done(mul_done), .mul_result(mul_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
   );

   // Multiplier stand-in: counts while start is high, done on the last count.
   logic [4:0] m_ctr;
   logic [4:0] m_stop;

   always_comb begin
      m_stop = 5'd31;
      case (mul_pw)
         c_PW_2:  m_stop = 5'd15;
         c_PW_4:  m_stop = 5'd7;
         c_PW_8:  m_stop = 5'd3;
         c_PW_16: m_stop = 5'd1;
         default: m_stop = 5'd31;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn)      m_ctr <= '0;
      else if (mul_start) m_ctr <= mul_done ? 5'd0 : m_ctr + 5'd1;
   end

   assign mul_done = mul_start && (m_ctr == m_stop);

   function automatic logic [63:0] pmul(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] pw);
      int w;
      logic [63:0] mask, la, lb, prod, lo, hi;
      case (pw)
         c_PW_2:  w = 16;
         c_PW_4:  w = 8;
         c_PW_8:  w = 4;
         c_PW_16: w = 2;
         default: w = 32;
      endcase
      mask = (64'd1 << w) - 64'd1;
      lo = '0;
      hi = '0;
      for (int i = 0; i < 32 / w; i++) begin
         la   = ({32'd0, a} >> (i * w)) & mask;
         lb   = ({32'd0, b} >> (i * w)) & mask;
         prod = la * lb;
         lo   = lo | ((prod & mask) << (i * w));
         hi   = hi | (((prod >> w) & mask) << (i * w));
      end
      return {hi[31:0], lo[31:0]};
   endfunction

   always_comb mul_result = pmul(mul_a, mul_b, mul_pw);

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  pw;
      logic        hi;
      logic [3:0]  rd;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called one step after an edge with the DUT idle; returns in the first RESP period.
   task automatic issue(input vec_t v, output int lat, output int starts, output int bad);
      lat = 0; starts = 0; bad = 0;
      req_valid = 1'b1; req_a = v.a; req_b = v.b; req_pw = v.pw; req_hi = v.hi; req_rd = v.rd;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      for (int n = 1; n <= 64; n++) begin
         if (rsp_valid) begin
            lat = n;
            break;
         end
         if (mul_start) begin
            starts++;
            if (mul_a !== v.a || mul_b !== v.b || mul_pw !== v.pw) bad++;
         end
         @(posedge g_clk); #1;
      end
   endtask

   initial begin
      int lat, starts, bad, last_start, first_ready, saw_rsp;
      vecs[0] = '{32'h0001_0003, 32'h0000_0005, c_PW_1,  1'b0, 4'd7,  32'h0005_000F, 1'b0, 33};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, c_PW_1,  1'b1, 4'd1,  32'hFFFF_FFFE, 1'b0, 33};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, c_PW_16, 1'b0, 4'd2,  32'h5555_5555, 1'b0, 3};
      vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, c_PW_16, 1'b1, 4'd4,  32'hAAAA_AAAA, 1'b0, 3};
      vecs[4] = '{32'h0102_0304, 32'h0506_0708, c_PW_4,  1'b0, 4'd5,  32'h050C_1520, 1'b0, 9};
      vecs[5] = '{32'h10FF_0304, 32'h10FF_0708, c_PW_4,  1'b1, 4'd6,  32'h01FE_0000, 1'b0, 9};
      vecs[6] = '{32'h0002_0003, 32'h0004_0005, c_PW_2,  1'b0, 4'd8,  32'h0008_000F, 1'b0, 17};
      vecs[7] = '{32'h0000_00F3, 32'h0000_00F2, c_PW_8,  1'b0, 4'd9,  32'h0000_0016, 1'b0, 5};
      vecs[8] = '{32'h0000_1234, 32'h0000_5678, 3'b000,  1'b0, 4'd3,  32'h0000_0000, 1'b1, 1};

      repeat (2) @(posedge g_clk);
      #1;
      check("reset_req_ready", req_ready, 1);
      check("reset_mul_start", mul_start, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_mul_a", mul_a, 0);
      check("reset_rsp_data", rsp_data, 0);
      g_resetn = 1'b1;
      @(posedge g_clk); #1;

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i], lat, starts, bad);
         check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_start_cycles", i), starts, vecs[i].exp_lat - 1);
         check($sformatf("v%0d_operand_unstable", i), bad, 0);
         check($sformatf("v%0d_data", i), rsp_data, vecs[i].exp_data);
         check($sformatf("v%0d_rd", i), rsp_rd, vecs[i].rd);
         check($sformatf("v%0d_err", i), rsp_err, vecs[i].exp_err);
         rsp_ready = 1'b1;
         @(posedge g_clk); #1;
         rsp_ready = 1'b0;
         check($sformatf("v%0d_release", i), {rsp_valid, req_ready}, 2'b01);
      end

      // Flush in RUN cycle 10: multiplier must still be run to completion.
      req_valid = 1'b1; req_a = vecs[0].a; req_b = vecs[0].b; req_pw = c_PW_1; req_hi = 1'b0;
      req_rd = 4'd7;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      last_start = 0; first_ready = 0; saw_rsp = 0;
      for (int n = 1; n <= 40; n++) begin
         flush = (n == 10);
         if (rsp_valid) saw_rsp = 1;
         if (mul_start) last_start = n;
         if (req_ready && first_ready == 0) first_ready = n;
         @(posedge g_clk); #1;
      end
      flush = 1'b0;
      check("flush_last_start", last_start, 32);
      check("flush_no_rsp", saw_rsp, 0);
      check("flush_ready_return", first_ready, 33);
      issue(vecs[4], lat, starts, bad);
      check("after_flush_latency", lat, 9);
      check("after_flush_data", rsp_data, vecs[4].exp_data);
      rsp_ready = 1'b1;
      @(posedge g_clk); #1;
      rsp_ready = 1'b0;

      // Backpressure: 20 stalled cycles with outputs frozen.
      issue(vecs[2], lat, starts, bad);
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         if (!rsp_valid || req_ready || rsp_data !== vecs[2].exp_data ||
             rsp_rd !== vecs[2].rd || rsp_err !== 1'b0) bad++;
         @(posedge g_clk); #1;
      end
      check("stall_hold_bad_cycles", bad, 0);
      rsp_ready = 1'b1;
      @(posedge g_clk); #1;
      rsp_ready = 1'b0;
      check("stall_release", {rsp_valid, req_ready}, 2'b01);

      issue(vecs[3], lat, starts, bad);
      check("pre_flush_resp", rsp_valid, 1);
      flush = 1'b1;
      @(posedge g_clk); #1;
      flush = 1'b0;
      check("resp_flush_drop", {rsp_valid, req_ready}, 2'b01);

      // Asynchronous reset between clock edges in the middle of a run.
      req_valid = 1'b1; req_a = vecs[1].a; req_b = vecs[1].b; req_pw = c_PW_1; req_hi = 1'b1;
      req_rd = 4'd1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge g_clk);
      #3;
      g_resetn = 1'b0;
      #1;
      check("areset_state_outs", {req_ready, mul_start, rsp_valid}, 3'b100);
      check("areset_mul_ops", {mul_a, mul_b, 1'b0, mul_pw}, 0);
      check("areset_rsp", {rsp_data, rsp_rd, rsp_err}, 0);
      @(posedge g_clk); #1;
      g_resetn = 1'b1;
      @(posedge g_clk); #1;
      issue(vecs[0], lat, starts, bad);
      check("post_reset_latency", lat, 33);
      check("post_reset_data", rsp_data, vecs[0].exp_data);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
